// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller UART loopback blocks:
// write-side FSM encoding, gap length, default sizing and the FIFO room check.
package sdram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        PAD  = 2'd2,
        GAP  = 2'd3
    } wr_state_e;

    localparam int          GAP_CYCLES        = 2;
    localparam int          DEF_BUF_DEPTH     = 1024;
    localparam int          DEF_WR_FIFO_DEPTH = 512;
    localparam logic [23:0] DEF_TIMEOUT_MAX   = 24'd4_999_999;

    // Sum is formed at 11 bits so a nearly full FIFO plus a long burst cannot wrap.
    function automatic logic room_ok(input logic [9:0] fill, input logic [9:0] len,
                                     input logic [10:0] limit);
        logic [10:0] sum;
        sum = {1'b0, fill} + {1'b0, len};
        return (sum <= limit);
    endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Generic synchronous byte FIFO with a registered read port (q valid the
// cycle after pop). Push when full and pop when empty are ignored.
module sync_byte_fifo
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
)
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    q,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [7:0]    q_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign count     = count_r;
    assign q         = q_r;

    // Storage array write port; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and registered read data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            q_r      <= 8'h00;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                q_r      <= mem_r[rd_ptr_r];
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fifo_write.sv
// UART-to-SDRAM burst packer: buffers received bytes and streams full bursts
// into the SDRAM write FIFO. Define FIFO_WRITE_TIMEOUT_EN for padded idle flush.
module fifo_write
    import sdram_pkg::*;
#(
    parameter int          BUF_DEPTH     = DEF_BUF_DEPTH,
    parameter int          WR_FIFO_DEPTH = DEF_WR_FIFO_DEPTH,
    parameter logic [23:0] TIMEOUT_MAX   = DEF_TIMEOUT_MAX,
    parameter logic [7:0]  PAD_BYTE      = 8'h00
)
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_flag,
    input  logic [9:0]  burst_num,
    input  logic [9:0]  wr_fifo_num,
    output logic        wr_en,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        overflow
);

    localparam int          AW       = $clog2(BUF_DEPTH);
    localparam logic [10:0] WR_LIMIT = 11'(WR_FIFO_DEPTH);

    wr_state_e   state_r;
    logic [9:0]  xfer_cnt_r;
    logic [9:0]  rd_len_r;
    logic [9:0]  burst_len_r;
    logic [1:0]  gap_cnt_r;
    logic        busy_r;
    logic        wr_en_r;
    logic        pad_d_r;
    logic        overflow_r;

    logic        push_s;
    logic        buf_rd_s;
    logic        pad_s;
    logic [7:0]  buf_q_s;
    logic [AW:0] buf_count_s;
    logic [AW:0] burst_ext_s;
    logic        buf_full_s;
    logic        buf_empty_s;
    logic        room_s;
    logic        start_full_s;
    logic        unused_s;

    assign push_s       = rx_flag & ~buf_full_s;
    assign buf_rd_s     = (state_r == XFER);
    assign burst_ext_s  = (AW+1)'(burst_num);
    assign room_s       = room_ok(wr_fifo_num, burst_num, WR_LIMIT);
    assign start_full_s = (burst_num != 10'd0) && (buf_count_s >= burst_ext_s) && room_s;

    sync_byte_fifo #(.DEPTH(BUF_DEPTH), .AW(AW)) u_buf (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_s),
        .pop   (buf_rd_s),
        .din   (rx_data),
        .q     (buf_q_s),
        .count (buf_count_s),
        .full  (buf_full_s),
        .empty (buf_empty_s)
    );

`ifdef FIFO_WRITE_TIMEOUT_EN
    logic [23:0] idle_cnt_r;
    logic        partial_s;
    logic        start_flush_s;

    assign pad_s         = (state_r == PAD);
    assign partial_s     = (buf_count_s != {(AW+1){1'b0}}) && (buf_count_s < burst_ext_s);
    assign start_flush_s = (state_r == IDLE) && partial_s && (idle_cnt_r == TIMEOUT_MAX) && room_s;
    assign unused_s      = buf_empty_s;

    // Idle-time counter for partial bursts; saturates at the flush threshold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_cnt_r <= 24'd0;
        end else if (rx_flag || (state_r != IDLE) || !partial_s || start_flush_s) begin
            idle_cnt_r <= 24'd0;
        end else if (idle_cnt_r != TIMEOUT_MAX) begin
            idle_cnt_r <= idle_cnt_r + 24'd1;
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end
`else
    assign pad_s    = 1'b0;
    assign unused_s = ^{buf_empty_s, TIMEOUT_MAX, burst_len_r};
`endif

    // Burst sequencing FSM; busy is registered alongside the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            xfer_cnt_r  <= 10'd0;
            rd_len_r    <= 10'd0;
            burst_len_r <= 10'd0;
            gap_cnt_r   <= 2'd0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    xfer_cnt_r <= 10'd0;
                    gap_cnt_r  <= 2'd0;
                    if (start_full_s) begin
                        state_r     <= XFER;
                        rd_len_r    <= burst_num;
                        burst_len_r <= burst_num;
                        busy_r      <= 1'b1;
`ifdef FIFO_WRITE_TIMEOUT_EN
                    end else if (start_flush_s) begin
                        state_r     <= XFER;
                        rd_len_r    <= 10'(buf_count_s);
                        burst_len_r <= burst_num;
                        busy_r      <= 1'b1;
`endif
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                XFER: begin
                    xfer_cnt_r <= xfer_cnt_r + 10'd1;
                    if (xfer_cnt_r == rd_len_r - 10'd1) begin
`ifdef FIFO_WRITE_TIMEOUT_EN
                        state_r <= (rd_len_r < burst_len_r) ? PAD : GAP;
`else
                        state_r <= GAP;
`endif
                    end else begin
                        state_r <= XFER;
                    end
                end
`ifdef FIFO_WRITE_TIMEOUT_EN
                PAD: begin
                    xfer_cnt_r <= xfer_cnt_r + 10'd1;
                    if (xfer_cnt_r == burst_len_r - 10'd1) begin
                        state_r <= GAP;
                    end else begin
                        state_r <= PAD;
                    end
                end
`endif
                GAP: begin
                    if (gap_cnt_r == 2'(GAP_CYCLES - 1)) begin
                        state_r   <= IDLE;
                        gap_cnt_r <= 2'd0;
                        busy_r    <= 1'b0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 2'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output strobe pipeline aligned with the buffer's registered read data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en_r <= 1'b0;
            pad_d_r <= 1'b0;
        end else begin
            wr_en_r <= buf_rd_s | pad_s;
            pad_d_r <= pad_s;
        end
    end

    // Sticky drop flag: a full buffer loses the byte even if a pop coincides.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_r <= 1'b0;
        end else if (rx_flag && buf_full_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign wr_en    = wr_en_r;
    assign wr_data  = pad_d_r ? PAD_BYTE : buf_q_s;
    assign busy     = busy_r;
    assign overflow = overflow_r;

endmodule
